// File: rtl/poly_pkg.sv
// Shared sizing and state encoding for the polynomial coefficient RAM reader.
package poly_pkg;

  localparam int COEF_WIDTH = 16;
  localparam int POLY_LEN   = 512;
  localparam int POLY_AW    = $clog2(POLY_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/pair_fifo2.sv
// Two-entry first-word-fall-through FIFO holding one {last, odd, even} pair per entry.
module pair_fifo2 #(
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [1:0]    occ_o
);

  logic [DW-1:0] mem_q [2];
  logic          wr_q;
  logic          rd_q;
  logic [1:0]    occ_q;
  logic          pop_en;
  logic          push_en;

  assign pop_en  = pop_i && (occ_q != 2'd0);
  // A full FIFO still accepts a push in the cycle it is being popped.
  assign push_en = push_i && ((occ_q != 2'd2) || pop_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_en) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (pop_en) begin
        rd_q <= ~rd_q;
      end
      case ({push_en, pop_en})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign valid_o = (occ_q != 2'd0);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign occ_o   = occ_q;

endmodule

// File: rtl/poly_ram_reader.sv
// Reads a whole polynomial out of the dual-port coefficient RAM as {odd, even}
// pairs and streams them downstream through a two-entry buffer.
module poly_ram_reader
  import poly_pkg::*;
#(
  parameter  int WIDTH  = COEF_WIDTH,
  parameter  int LENGTH = POLY_LEN,
  localparam int AW     = $clog2(LENGTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               ena,
  output logic               enb,
  output logic               wea,
  output logic               web,
  output logic [AW-1:0]      addra,
  output logic [AW-1:0]      addrb,
  input  logic [WIDTH-1:0]   doa,
  input  logic [WIDTH-1:0]   dob,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic               out_last
);

  localparam int            KW     = AW - 1;
  localparam logic [KW-1:0] K_LAST = KW'(LENGTH / 2 - 1);

  state_e        state_q;
  logic [KW-1:0] k_q;
  logic          pending_q;
  logic          last_pend_q;
  logic          busy_q;
  logic          done_q;

  logic [1:0]       occ;
  logic             fifo_valid;
  logic [2*WIDTH:0] head;
  logic             pop;
  logic [2:0]       load;
  logic             issue;
  logic             k_last;

  assign pop    = fifo_valid & out_ready;
  // Buffered pairs plus the read in flight, after this cycle's pop leaves.
  assign load   = {1'b0, occ} + {2'b00, pending_q} - {2'b00, pop};
  assign issue  = (state_q == ST_ISSUE) && (load < 3'd2);
  assign k_last = (k_q == K_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      pending_q   <= 1'b0;
      last_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pending_q   <= issue;
      last_pend_q <= issue & k_last;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The done cycle is already IDLE, so a start there must not count.
          if (start && !done_q) begin
            state_q <= ST_ISSUE;
            k_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            if (k_last) begin
              state_q <= ST_DRAIN;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (!pending_q && (occ == {1'b0, pop})) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  pair_fifo2 #(
    .DW(2 * WIDTH + 1)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (pending_q),
    .data_i ({last_pend_q, dob, doa}),
    .pop_i  (pop),
    .valid_o(fifo_valid),
    .data_o (head),
    .occ_o  (occ)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign ena       = issue;
  assign enb       = issue;
  assign wea       = 1'b0;
  assign web       = 1'b0;
  assign addra     = {k_q, 1'b0};
  assign addrb     = {k_q, 1'b1};
  assign out_valid = fifo_valid;
  assign out_data  = head[2*WIDTH-1:0];
  assign out_last  = head[2*WIDTH];

endmodule

// File: tb/tb_poly_ram_reader.sv
// Bench for poly_ram_reader: RAM model, stream scoreboard, directed tables and random backpressure.
module tb_poly_ram_reader;

  localparam int NB = 256;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, out_ready;
  logic        busy, done, ena, enb, wea, web, out_valid, out_last;
  logic [8:0]  addra, addrb;
  logic [15:0] doa, dob;
  logic [31:0] out_data;

  logic        s_start, s_ready;
  logic        s_busy, s_done, s_ena, s_enb, s_wea, s_web, s_valid, s_last;
  logic [1:0]  s_addra, s_addrb;
  logic [15:0] s_doa, s_dob;
  logic [31:0] s_data;

  logic [15:0] mem [512];
  logic [15:0] s_mem [4];

  poly_ram_reader u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ena(ena), .enb(enb), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
    .doa(doa), .dob(dob), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  poly_ram_reader #(.WIDTH(16), .LENGTH(4)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .ena(s_ena), .enb(s_enb), .wea(s_wea), .web(s_web), .addra(s_addra), .addrb(s_addrb),
    .doa(s_doa), .dob(s_dob), .out_valid(s_valid), .out_ready(s_ready),
    .out_data(s_data), .out_last(s_last)
  );

  // Synchronous-read RAM models: data one clock after an enabled access.
  always @(posedge clk) begin
    if (ena) doa <= mem[addra];
    if (enb) dob <= mem[addrb];
    if (s_ena) s_doa <= s_mem[s_addra];
    if (s_enb) s_dob <= s_mem[s_addrb];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_ready = 0, ready_force = 0, start_nxt = 0, rst_nxt = 1, s_start_nxt = 0;

  int iss, pops, done_cnt, last_cnt, first_ena, first_val, first_pop, last_pop;
  bit prev_valid, prev_ready;
  logic [31:0] prev_data;

  typedef struct {
    bit          rdy;
    int          reps;
    bit          ena;
    int          addra;
    bit          valid;
    logic [31:0] data;
  } row_t;
  row_t rows [8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic clear_mon();
    iss = 0; pops = 0; done_cnt = 0; last_cnt = 0;
    first_ena = -1; first_val = -1; first_pop = -1; last_pop = -1;
    prev_valid = 0; prev_ready = 0; prev_data = '0;
  endtask

  // Scoreboard: expected beat p is {mem[2p+1], mem[2p]}, last only on p=NB-1.
  task automatic monitor();
    int pop_now;
    logic [31:0] exp_d;
    if (rst) begin
      clear_mon();
      return;
    end
    pop_now = (out_valid && out_ready) ? 1 : 0;
    if (ena) begin
      check("enb_with_ena", enb, 1);
      check("addra", addra, 64'(2 * iss));
      check("addrb", addrb, 64'(2 * iss + 1));
      check("inflight_le2", ((iss - pops - pop_now + 1) <= 2), 1);
      if (iss == 0) first_ena = cyc;
      iss++;
    end
    if (prev_valid && !prev_ready) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, prev_data);
    end
    if (out_valid && first_val < 0) first_val = cyc;
    if (pop_now == 1) begin
      if (pops < NB) begin
        exp_d = {mem[2*pops+1], mem[2*pops]};
        check("beat_data", out_data, exp_d);
        check("beat_last", out_last, (pops == NB - 1));
      end else begin
        check("extra_beat", pops, NB - 1);
      end
      if (out_last) last_cnt++;
      if (pops == 0) first_pop = cyc;
      last_pop = cyc;
      pops++;
    end
    if (done) begin
      check("done_busy_low", busy, 0);
      check("done_after_pop", cyc - last_pop, 1);
      check("done_beats", pops, NB);
      done_cnt++;
    end
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_data  = out_data;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    rst       = rst_nxt;
    start     = start_nxt;
    s_start   = s_start_nxt;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ena"}, ena, 0);
    check({tag, "_enb"}, enb, 0);
    check({tag, "_wea"}, wea, 0);
    check({tag, "_web"}, web, 0);
    check({tag, "_addra"}, addra, 0);
    check({tag, "_addrb"}, addrb, 1);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_data"}, out_data, 0);
  endtask

  task automatic pulse_start();
    start_nxt = 1;
    tick();
    start_nxt = 0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        seen = 1;
        break;
      end
    end
    check("done_timeout", seen, 1);
  endtask

  task automatic pass_end_checks(input string tag);
    check({tag, "_issued"}, iss, NB);
    check({tag, "_beats"}, pops, NB);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_last_cnt"}, last_cnt, 1);
  endtask

  initial begin
    int t0;
    bit hit;
    rst = 1; start = 0; out_ready = 0; s_start = 0; s_ready = 1;
    doa = '0; dob = '0; s_doa = '0; s_dob = '0;
    for (int i = 0; i < 512; i++) mem[i] = 16'(i);
    for (int i = 0; i < 4; i++) s_mem[i] = 16'(i);
    clear_mon();

    // Reset state
    tick();
    tick();
    check_reset_outputs("rst");
    rst_nxt = 0;
    tick();
    check_reset_outputs("idle");

    // Full pass, out_ready=1, identity RAM
    clear_mon();
    ready_force = 1;
    pulse_start();
    t0 = cyc;
    tick();
    check("busy_after_start", busy, 1);
    wait_done(1000);
    check("first_ena_latency", first_ena - t0, 1);
    check("first_valid_latency", first_val - first_ena, 2);
    check("back_to_back", last_pop - first_pop, NB - 1);
    pass_end_checks("full");

    // Random backpressure, random RAM contents
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    clear_mon();
    rand_ready = 1;
    pulse_start();
    wait_done(3000);
    pass_end_checks("rand");
    rand_ready = 0;

    // Stall 20 cycles after start, then release: table of per-cycle expectations
    for (int i = 0; i < 512; i++) mem[i] = 16'(i);
    rows[0] = '{0, 1, 1, 0, 0, 32'h0};
    rows[1] = '{0, 1, 1, 2, 0, 32'h0};
    rows[2] = '{0, 1, 0, 4, 1, 32'h0001_0000};
    rows[3] = '{0, 17, 0, 4, 1, 32'h0001_0000};
    rows[4] = '{1, 1, 1, 4, 1, 32'h0001_0000};
    rows[5] = '{1, 1, 1, 6, 1, 32'h0003_0002};
    rows[6] = '{1, 1, 1, 8, 1, 32'h0005_0004};
    rows[7] = '{1, 1, 1, 10, 1, 32'h0007_0006};
    clear_mon();
    ready_force = 0;
    pulse_start();
    for (int r = 0; r < 8; r++) begin
      for (int n = 0; n < rows[r].reps; n++) begin
        ready_force = rows[r].rdy;
        tick();
        check($sformatf("tbl%0d_ena", r), ena, rows[r].ena);
        check($sformatf("tbl%0d_addra", r), addra, 64'(rows[r].addra));
        check($sformatf("tbl%0d_valid", r), out_valid, rows[r].valid);
        if (rows[r].valid) check($sformatf("tbl%0d_data", r), out_data, rows[r].data);
      end
    end
    ready_force = 1;
    wait_done(1000);
    pass_end_checks("stall");

    // start re-pulsed during ISSUE and in the done cycle
    clear_mon();
    pulse_start();
    repeat (40) tick();
    pulse_start();
    hit = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (out_valid && out_ready && out_last) begin
        hit = 1;
        break;
      end
    end
    check("restart_last_seen", hit, 1);
    start_nxt = 1;
    tick();
    check("restart_done_cycle", done, 1);
    start_nxt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_restart_busy", busy, 0);
      check("no_restart_ena", ena, 0);
    end
    pass_end_checks("restart");

    // Reset mid-pass, then a clean pass
    clear_mon();
    pulse_start();
    hit = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (pops > 100) begin
        hit = 1;
        break;
      end
    end
    check("midpass_reach_beat100", hit, 1);
    ready_force = 0;
    repeat (3) tick();
    rst_nxt = 1;
    tick();
    check_reset_outputs("midrst");
    tick();
    check_reset_outputs("midrst2");
    rst_nxt = 0;
    tick();
    check_reset_outputs("postrst");
    tick();
    check("postrst_fifo_empty", out_valid, 0);
    ready_force = 1;
    clear_mon();
    pulse_start();
    wait_done(1000);
    pass_end_checks("fresh");

    // LENGTH=4 instance
    s_start_nxt = 1;
    tick();
    s_start_nxt = 0;
    tick();
    check("s_c1_ena", s_ena, 1);
    check("s_c1_addra", s_addra, 0);
    check("s_c1_addrb", s_addrb, 1);
    tick();
    check("s_c2_ena", s_ena, 1);
    check("s_c2_addra", s_addra, 2);
    check("s_c2_addrb", s_addrb, 3);
    tick();
    check("s_c3_ena", s_ena, 0);
    check("s_c3_valid", s_valid, 1);
    check("s_c3_data", s_data, 32'h0001_0000);
    check("s_c3_last", s_last, 0);
    tick();
    check("s_c4_valid", s_valid, 1);
    check("s_c4_data", s_data, 32'h0003_0002);
    check("s_c4_last", s_last, 1);
    tick();
    check("s_c5_done", s_done, 1);
    check("s_c5_busy", s_busy, 0);
    check("s_c5_valid", s_valid, 0);
    tick();
    check("s_c6_done", s_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_ram_reader.md
Name: poly_ram_reader

Overview:
- Read-side initiator for the polynomial dual-port coefficient RAM.
- On start, reads all LENGTH coefficients as pairs: port A reads even addresses, port B reads odd addresses. The RAM returns data on doa/dob one clock after an enabled access.
- Emits pairs on a valid/ready stream, with flow control and a 2-entry output buffer. Feeds NTT/encode stages downstream.

Parameters:
- WIDTH, 16, coefficient width (matches RAM WIDTH).
- LENGTH, 512, coefficients per polynomial. Must be an even power of two, >=4.
- AW, $clog2(LENGTH), RAM address width (derived; not overridden).

Ports:
- clk  in  1  single clock; also drives RAM clka/clkb.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a read pass; ignored while busy.
- busy  out  1  high from the start-accept edge until done.
- done  out  1  one-cycle pulse after the final beat is accepted.
- ena  out  1  RAM port A enable.
- enb  out  1  RAM port B enable.
- wea  out  1  tied 0.
- web  out  1  tied 0.
- addra  out  AW  RAM port A address, always even.
- addrb  out  AW  RAM port B address, always addra+1.
- doa  in  WIDTH  RAM port A read data.
- dob  in  WIDTH  RAM port B read data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_data  out  2*WIDTH  {coef[2k+1], coef[2k]}.
- out_last  out  1  high with beat k = LENGTH/2-1.

Behaviour:
- Reset values: state IDLE; pair counter 0; pending 0; buffer empty.
  - Outputs: busy=0, done=0, ena=enb=0, addra=0, addrb=1, out_valid=0, out_last=0, out_data=0.
- States:
  - IDLE: start=1 -> ISSUE. Pair counter cleared; busy=1 from the next cycle.
  - ISSUE: issues reads until all LENGTH/2 pairs are issued, then -> DRAIN.
  - DRAIN: waits until pending=0 and buffer empty -> IDLE; done=1 for exactly that one cycle.
- Issue rule (combinational):
  - issue = (state==ISSUE) and (occ + pending - pop < 2), where pop = out_valid & out_ready.
  - ena = enb = issue.
  - addra = {k,1'b0}, addrb = {k,1'b1}, with k = registered pair counter; k increments on issue.
- pending register: set on an issue edge, cleared otherwise. Exactly one read can be outstanding.
- Buffer:
  - When pending=1, doa/dob are captured into the 2-entry FIFO at the next edge.
  - A simultaneous pop and capture keeps occ unchanged.
  - Overflow is impossible by the issue rule. The bench asserts this.
  - out_data/out_valid/out_last come from the FIFO head. out_last is stored per entry: set when the pair index equals LENGTH/2-1.
- Latency:
  - start sampled at edge 0; ena high during cycle 1.
  - First out_valid after edge 2 (2 cycles after the first issue).
  - Sustained throughput: 1 beat/cycle while out_ready=1.
- Backpressure: out_valid/out_data stay stable while out_ready=0. No beat is lost or duplicated.
- Wrap: k never wraps within a pass. The counter is AW-1 bits plus terminal detect at LENGTH/2-1.
- start during ISSUE/DRAIN: ignored, with no effect on counters.
- start in the same cycle as done: ignored. A new pass requires start while IDLE.
- Reset mid-pass: immediate return to reset values. Any in-flight RAM data is discarded; the FIFO is cleared.
- Stream contract: out_valid is never deasserted without a pop.

Decomposition:
- Shared package poly_pkg holds:
  - COEF_WIDTH=16, POLY_LEN=512, derived address width;
  - state encoding localparams (IDLE, ISSUE, DRAIN).
- One natural sub-module: pair_fifo2, a 2-entry first-word-fall-through FIFO of 2*WIDTH+1 bits, with push/pop/occ outputs.
- The FSM and issue logic stay in poly_ram_reader.

Test Plan:
- RAM preloaded with mem[i]=i, out_ready=1, pulse start -> 256 beats on consecutive cycles.
  - Beat k = {2k+1, 2k}.
  - First out_valid 2 cycles after the first ena.
  - out_last on beat 255 only; done pulse 1 cycle after that pop; busy drops with done.
- out_ready pseudo-random (50%) over a full pass -> all 256 pairs in order, no duplicates.
  - occ+pending never exceeds 2; out_data stable while stalled.
- out_ready=0 for 20 cycles after start -> ena high for exactly 2 cycles, then low.
  - On release, beats 0,1 pop back-to-back and issue resumes at k=2.
- start re-pulsed during ISSUE and in the done cycle -> no restart; exactly one pass of 256 beats and one done pulse.
- rst asserted mid-pass (after beat 100, out_ready=0) -> all outputs at reset values while rst is high, FIFO empty.
  - A fresh start then yields beats 0..255 correctly.
- LENGTH=4 build -> 2 beats: {1,0} then {3,2} with out_last; addresses 0/1, then 2/3.
